// File: rtl/maze_pkg.sv
// Shared types for the maze walker: move directions and FSM states.
// Counter option: define MAZE_WALKER_MOVE_CNT_EN to build move_cnt.
package maze_pkg;

    typedef enum logic [1:0] {
        DIR_YDEC = 2'b00,
        DIR_XINC = 2'b01,
        DIR_XDEC = 2'b10,
        DIR_YINC = 2'b11
    } dir_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        READY = 2'b01,
        BUSY  = 2'b10
    } state_t;

endpackage

// File: rtl/loc_stack.sv
// LIFO of visited locations; top entry is always visible on dout.
// Push has priority over pop; clear empties the stack in one cycle.
module loc_stack #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNTW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [CNTW-1:0]  cnt;
    logic [CNTW-1:0]  top;

    assign empty = (cnt == '0);
    assign full  = (cnt == CNTW'(DEPTH));
    assign top   = cnt - CNTW'(1);
    assign dout  = mem[top[AW-1:0]];

    // Storage needs no reset: cnt alone defines which entries are live.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[cnt[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (push && !full) begin
            cnt <= cnt + CNTW'(1);
        end else if (pop && !empty) begin
            cnt <= cnt - CNTW'(1);
        end
    end

endmodule

// File: rtl/maze_walker.sv
// Grid walker with backtrack stack, edge blocking and error pulses.
// Define MAZE_WALKER_MOVE_CNT_EN to build the move_cnt counter.
module maze_walker
    import maze_pkg::*;
#(
    parameter int CW    = 4,
    parameter int DEPTH = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic [2*CW-1:0] start_loc,
    input  logic [2*CW-1:0] goal_loc,
    input  logic            step_valid,
    input  logic [1:0]      step_dir,
    output logic            step_ready,
    input  logic            back_valid,
    output logic [2*CW-1:0] cur_loc,
    output logic            edge_err,
    output logic            empty_err,
    output logic            full_err,
    output logic            stack_empty,
    output logic            stack_full,
    output logic            goal_hit,
    output logic [15:0]     move_cnt
);

    state_t          state;
    logic [CW-1:0]   x;
    logic [CW-1:0]   y;
    logic [CW-1:0]   nx;
    logic [CW-1:0]   ny;
    logic            blocked;
    logic [2*CW-1:0] next_loc;
    logic [2*CW-1:0] top_loc;
    logic            accept_step;
    logic            accept_back;
    logic            do_push;
    logic            do_pop;

    assign x        = cur_loc[2*CW-1:CW];
    assign y        = cur_loc[CW-1:0];
    assign next_loc = {nx, ny};

    always_comb begin
        nx      = x;
        ny      = y;
        blocked = 1'b0;
        unique case (dir_t'(step_dir))
            DIR_YDEC: begin
                blocked = (y == '0);
                ny      = y - CW'(1);
            end
            DIR_XINC: begin
                blocked = (x == '1);
                nx      = x + CW'(1);
            end
            DIR_XDEC: begin
                blocked = (x == '0);
                nx      = x - CW'(1);
            end
            DIR_YINC: begin
                blocked = (y == '1);
                ny      = y + CW'(1);
            end
        endcase
    end

    // Step beats back; load beats both.
    assign accept_step = (state == READY) && step_valid && !load;
    assign accept_back = (state == READY) && back_valid
                         && !step_valid && !load;
    assign do_push     = accept_step && !stack_full && !blocked;
    assign do_pop      = accept_back && !stack_empty;

    assign goal_hit = (state != IDLE) && (cur_loc == goal_loc);

    loc_stack #(
        .WIDTH(2*CW),
        .DEPTH(DEPTH)
    ) u_stack (
        .clk  (clk),
        .rst  (rst),
        .clear(load),
        .push (do_push),
        .pop  (do_pop),
        .din  (cur_loc),
        .dout (top_loc),
        .empty(stack_empty),
        .full (stack_full)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            step_ready <= 1'b0;
            cur_loc    <= '0;
            edge_err   <= 1'b0;
            empty_err  <= 1'b0;
            full_err   <= 1'b0;
        end else begin
            edge_err  <= 1'b0;
            empty_err <= 1'b0;
            full_err  <= 1'b0;
            if (load) begin
                state      <= READY;
                step_ready <= 1'b1;
                cur_loc    <= start_loc;
            end else begin
                unique case (state)
                    IDLE: begin
                        step_ready <= 1'b0;
                    end
                    READY: begin
                        if (accept_step) begin
                            state      <= BUSY;
                            step_ready <= 1'b0;
                            if (stack_full) begin
                                full_err <= 1'b1;
                            end else if (blocked) begin
                                edge_err <= 1'b1;
                            end else begin
                                cur_loc <= next_loc;
                            end
                        end else if (accept_back) begin
                            state      <= BUSY;
                            step_ready <= 1'b0;
                            if (stack_empty) begin
                                empty_err <= 1'b1;
                            end else begin
                                cur_loc <= top_loc;
                            end
                        end
                    end
                    BUSY: begin
                        state      <= READY;
                        step_ready <= 1'b1;
                    end
                    default: begin
                        state      <= IDLE;
                        step_ready <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef MAZE_WALKER_MOVE_CNT_EN
    logic [15:0] cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= '0;
        end else if ((do_push || do_pop) && cnt_q != 16'hFFFF) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign move_cnt = cnt_q;
`else
    assign move_cnt = '0;
`endif

endmodule

// File: tb/tb_maze_walker.sv
// Randomized bench for maze_walker against a queue-based grid model.
// Honours MAZE_WALKER_MOVE_CNT_EN when computing expected move_cnt.
module tb_maze_walker;

    localparam int CW    = 4;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        load = 1'b0;
    logic [7:0]  start_loc = '0;
    logic [7:0]  goal_loc = 8'hFF;
    logic        step_valid = 1'b0;
    logic [1:0]  step_dir = '0;
    logic        back_valid = 1'b0;
    logic        step_ready;
    logic [7:0]  cur_loc;
    logic        edge_err;
    logic        empty_err;
    logic        full_err;
    logic        stack_empty;
    logic        stack_full;
    logic        goal_hit;
    logic [15:0] move_cnt;

    maze_walker #(.CW(CW), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .start_loc  (start_loc),
        .goal_loc   (goal_loc),
        .step_valid (step_valid),
        .step_dir   (step_dir),
        .step_ready (step_ready),
        .back_valid (back_valid),
        .cur_loc    (cur_loc),
        .edge_err   (edge_err),
        .empty_err  (empty_err),
        .full_err   (full_err),
        .stack_empty(stack_empty),
        .stack_full (stack_full),
        .goal_hit   (goal_hit),
        .move_cnt   (move_cnt)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: position, visited-location stack, counters.
    logic [7:0] m_loc = '0;
    logic [7:0] m_stk [$];
    int         m_cnt = 0;
    bit         m_idle = 1'b1;
    bit         m_busy = 1'b0;
    bit [2:0]   m_err = '0;  // {edge, empty, full}

    function automatic logic [30:0] expv();
        logic [15:0] c;
`ifdef MAZE_WALKER_MOVE_CNT_EN
        c = (m_cnt > 65535) ? 16'hFFFF : 16'(m_cnt);
`else
        c = '0;
`endif
        return {m_loc, !m_idle && !m_busy,
                !m_idle && (m_loc == goal_loc),
                m_busy ? m_err : 3'b000,
                m_stk.size() == 0, m_stk.size() == DEPTH, c};
    endfunction

    function automatic logic [30:0] actv();
        return {cur_loc, step_ready, goal_hit, edge_err, empty_err,
                full_err, stack_empty, stack_full, move_cnt};
    endfunction

    function automatic void model_req(bit s, bit b, logic [1:0] d);
        int x;
        int y;
        m_err = '0;
        if (m_idle || (!s && !b)) return;
        m_busy = 1'b1;
        if (s) begin
            x = int'(m_loc[7:4]);
            y = int'(m_loc[3:0]);
            case (d)
                2'd0: y = y - 1;
                2'd1: x = x + 1;
                2'd2: x = x - 1;
                default: y = y + 1;
            endcase
            if (m_stk.size() == DEPTH) begin
                m_err = 3'b001;
            end else if (x < 0 || x > 15 || y < 0 || y > 15) begin
                m_err = 3'b100;
            end else begin
                m_stk.push_back(m_loc);
                m_loc = {x[3:0], y[3:0]};
                m_cnt++;
            end
        end else if (m_stk.size() == 0) begin
            m_err = 3'b010;
        end else begin
            m_loc = m_stk.pop_back();
            m_cnt++;
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        m_busy = 1'b0;
    endtask

    task automatic drive_req(bit s, bit b, logic [1:0] d);
        step_valid = s;
        back_valid = b;
        step_dir   = d;
        @(posedge clk);
        #1;
        step_valid = 1'b0;
        back_valid = 1'b0;
        m_busy     = 1'b0;
        model_req(s, b, d);
    endtask

    task automatic do_load(logic [7:0] v);
        load      = 1'b1;
        start_loc = v;
        @(posedge clk);
        #1;
        load   = 1'b0;
        m_loc  = v;
        m_stk.delete();
        m_cnt  = 0;
        m_idle = 1'b0;
        m_busy = 1'b0;
        m_err  = '0;
    endtask

    function automatic logic [7:0] rand_loc();
        logic [3:0] c [2];
        for (int i = 0; i < 2; i++) begin
            case ($urandom_range(0, 4))
                0: c[i] = 4'h0;
                1: c[i] = 4'h1;
                2: c[i] = 4'hE;
                3: c[i] = 4'hF;
                default: c[i] = 4'($urandom_range(0, 15));
            endcase
        end
        return {c[0], c[1]};
    endfunction

    task automatic test_reset();
        step_valid = 1'b1;
        back_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if (actv() !== expv()) begin
            fails++;
            $display("FAIL reset_hold: got %h expected %h", actv(), expv());
        end
        rst = 1'b1;
        repeat (2) tick();
        tests++;
        if (actv() !== expv()) begin
            fails++;
            $display("FAIL idle_ignore: got %h expected %h", actv(), expv());
        end
        step_valid = 1'b0;
        back_valid = 1'b0;
    endtask

    task automatic test_step_basic();
        goal_loc = 8'hFF;
        do_load(8'h00);
        tests++;
        if (actv() !== expv()) begin
            fails++;
            $display("FAIL load: got %h expected %h", actv(), expv());
        end
        drive_req(1'b1, 1'b0, 2'b01);
        tests++;
        if (actv() !== expv() || cur_loc !== 8'h10) begin
            fails++;
            $display("FAIL step_busy: got %h expected %h", actv(), expv());
        end
        tick();
        tests++;
        if (actv() !== expv()) begin
            fails++;
            $display("FAIL step_ready: got %h expected %h", actv(), expv());
        end
    endtask

    task automatic test_edge();
        logic [7:0] locs [4] = '{8'h00, 8'h00, 8'hF0, 8'h0F};
        logic [1:0] dirs [4] = '{2'b00, 2'b10, 2'b01, 2'b11};
        for (int i = 0; i < 4; i++) begin
            do_load(locs[i]);
            drive_req(1'b1, 1'b0, dirs[i]);
            tests++;
            if (actv() !== expv() || edge_err !== 1'b1) begin
                fails++;
                $display("FAIL edge_%0d: got %h expected %h",
                         i, actv(), expv());
            end
            tick();
            tests++;
            if (actv() !== expv()) begin
                fails++;
                $display("FAIL edge_clr_%0d: got %h expected %h",
                         i, actv(), expv());
            end
        end
    endtask

    task automatic test_goal();
        goal_loc = 8'hFF;
        do_load(8'hFE);
        drive_req(1'b1, 1'b0, 2'b11);
        tick();
        tests++;
        if (actv() !== expv() || goal_hit !== 1'b1) begin
            fails++;
            $display("FAIL goal_hit: got %h expected %h", actv(), expv());
        end
        drive_req(1'b0, 1'b1, 2'b00);
        tick();
        tests++;
        if (actv() !== expv() || cur_loc !== 8'hFE) begin
            fails++;
            $display("FAIL goal_back: got %h expected %h", actv(), expv());
        end
    endtask

    task automatic test_full_empty();
        do_load(8'h55);
        for (int i = 0; i < 10; i++) begin
            if (i < 5) drive_req(1'b1, 1'b0, 2'b01);
            else drive_req(1'b0, 1'b1, 2'b00);
            tests++;
            if (actv() !== expv()) begin
                fails++;
                $display("FAIL fullempty_%0d: got %h expected %h",
                         i, actv(), expv());
            end
            tick();
        end
    endtask

    task automatic test_both();
        do_load(8'h33);
        drive_req(1'b1, 1'b1, 2'b11);
        tests++;
        if (actv() !== expv() || step_ready !== 1'b0) begin
            fails++;
            $display("FAIL both_busy: got %h expected %h", actv(), expv());
        end
        tick();
        tests++;
        if (actv() !== expv() || step_ready !== 1'b1) begin
            fails++;
            $display("FAIL both_ready: got %h expected %h", actv(), expv());
        end
    endtask

    task automatic test_reset_busy();
        for (int i = 0; i < 2; i++) begin
            do_load(8'h00);
            drive_req(1'b1, 1'b0, 2'(i));
            #1;
            rst = 1'b0;
            #1;
            m_loc  = '0;
            m_stk.delete();
            m_cnt  = 0;
            m_idle = 1'b1;
            m_busy = 1'b0;
            tests++;
            if (actv() !== expv()) begin
                fails++;
                $display("FAIL rst_busy_%0d: got %h expected %h",
                         i, actv(), expv());
            end
            tick();
            rst = 1'b1;
            tick();
            tests++;
            if (actv() !== expv()) begin
                fails++;
                $display("FAIL rst_after_%0d: got %h expected %h",
                         i, actv(), expv());
            end
        end
    endtask

    task automatic test_random();
        int  r;
        bit  s;
        bit  b;
        do_load(rand_loc());
        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 99);
            if (r < 5) begin
                do_load(rand_loc());
            end else if (r < 15) begin
                tick();
            end else begin
                s = (r < 60);
                b = (r >= 45);
                drive_req(s, b, 2'($urandom_range(0, 3)));
                tests++;
                if (actv() !== expv()) begin
                    fails++;
                    $display("FAIL rand_busy_%0d: got %h expected %h",
                             i, actv(), expv());
                end
                tick();
            end
            tests++;
            if (actv() !== expv()) begin
                fails++;
                $display("FAIL rand_%0d: got %h expected %h",
                         i, actv(), expv());
            end
        end
    endtask

    initial begin
        test_reset();
        test_step_basic();
        test_edge();
        test_goal();
        test_full_empty();
        test_both();
        test_reset_busy();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/maze_walker.md
MAZE_WALKER -- requirements
Module: maze_walker

Interface
REQ-001 The block SHALL provide parameter CW, default 4, meaning width of one coordinate; a location is {X,Y}, 2*CW bits.
REQ-002 The block SHALL provide parameter DEPTH, default 16, meaning number of entries in the backtrack stack.
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port load, input, 1 bit: load start location.
REQ-006 Port start_loc, input, 2*CW bits: start location {X,Y}.
REQ-007 Port goal_loc, input, 2*CW bits: target location.
REQ-008 Ports step_valid (in, 1), step_dir (in, 2) and step_ready (out, 1): the move request handshake.
REQ-009 Port back_valid, input, 1 bit: backtrack request, sharing step_ready.
REQ-010 Port cur_loc, output, 2*CW bits: registered current location.
REQ-011 Ports edge_err, empty_err and full_err: outputs, 1 bit each, one-cycle error pulses.
REQ-012 Ports stack_empty and stack_full: outputs, 1 bit each, stack status.
REQ-013 Port goal_hit, output, 1 bit: asserted while cur_loc == goal_loc and the state is not IDLE.
REQ-014 Port move_cnt, output, 16 bits: accepted-move counter (see Configuration).

Function
REQ-015 FSM states SHALL be IDLE, READY and BUSY; step_ready SHALL be 1 only in READY.
REQ-016 load SHALL take effect in any state: cur_loc<=start_loc, stack cleared, move_cnt<=0, next state READY; load SHALL override any same-cycle step or back.
REQ-017 Direction encoding: 00 = Y-1, 01 = X+1, 10 = X-1, 11 = Y+1; axis = X when dir[1]^dir[0], increment when dir[0]=1.
REQ-018 Arithmetic SHALL be modulo 2^CW, but a move leaving the grid SHALL be blocked, never wrapped: coordinate 0 with decrement, or coordinate 2^CW-1 with increment.
REQ-019 A step SHALL be accepted on an edge where state=READY and step_valid=1, after which the next state SHALL be BUSY for exactly one cycle, then READY.
REQ-020 A legal accepted step SHALL push the old cur_loc, update cur_loc on the same edge, and increment move_cnt.
REQ-021 A blocked step SHALL leave cur_loc and the stack unchanged and SHALL pulse edge_err in the BUSY cycle.
REQ-022 A step while stack_full SHALL leave cur_loc and the stack unchanged and SHALL pulse full_err in the BUSY cycle; full is checked before edge.
REQ-023 An accepted back SHALL pop the stack into cur_loc and increment move_cnt; back while stack_empty SHALL change nothing and SHALL pulse empty_err in the BUSY cycle.
REQ-024 When step_valid and back_valid are both high, step SHALL win and back SHALL be dropped, not queued.
REQ-025 In IDLE, step_valid and back_valid SHALL be ignored.
REQ-026 Latency: cur_loc SHALL reflect an accepted request 1 cycle after acceptance, and the next acceptance SHALL be no earlier than 2 cycles after.
REQ-027 move_cnt SHALL saturate at 16'hFFFF.

Reset
REQ-028 While rst=0: state IDLE, cur_loc=0, stack empty, stack_empty=1, stack_full=0, all error pulses 0, goal_hit=0, step_ready=0, move_cnt=0.
REQ-029 Reset asserted mid-operation SHALL abandon any BUSY cycle without producing an error pulse.

Configuration
REQ-030 Macro MAZE_WALKER_MOVE_CNT_EN defined: the move_cnt counter SHALL be built and behave per REQ-016, REQ-020, REQ-023 and REQ-027.
REQ-031 Macro MAZE_WALKER_MOVE_CNT_EN not defined: the move_cnt port SHALL remain and be constant 0, and no counter register SHALL exist.

Structure
REQ-032 Shared package maze_pkg SHALL hold the direction encodings (DIR_YDEC, DIR_XINC, DIR_XDEC, DIR_YINC) and the FSM state type.
REQ-033 The LIFO SHALL be a sub-module loc_stack, parameters WIDTH and DEPTH, with push, pop, data in/out, empty and full.

Verification
REQ-034 Scenario: CW=4; load start 0x00; step 01 -> cur_loc 0x10 after 1 cycle, move_cnt 1, stack not empty.
REQ-035 Scenario: cur_loc 0x00; step 00 -> edge_err one pulse, cur_loc stays 0x00, move_cnt unchanged.
REQ-036 Scenario: cur_loc 0xFE; step 11 -> 0xFF, goal_hit=1 with goal 0xFF; back -> 0xFE, goal_hit=0.
REQ-037 Scenario: DEPTH=4; 4 legal steps then a 5th -> full_err pulse, cur_loc unchanged; after 4 backs plus 1 more back -> empty_err pulse.
REQ-038 Scenario: step_valid and back_valid both high in READY -> step performed, no pop; step_ready low for exactly one cycle.
REQ-039 Scenario: rst asserted in BUSY -> cur_loc 0, state IDLE, no error pulse; without the macro, move_cnt stays 0 throughout.
